// File: rtl/pcs_gearbox_tx.sv
// 66b->64b transmit gearbox: packs {payload, sync header} blocks LSB-first into 64-bit SerDes words.
// Latency: 1 cycle from block accept to the word carrying its first bits on data_o/valid_o.
// Backpressure: ready_o drops for one cycle in 33 while the 64-bit residue is flushed; upstream holds.
// Optional: define PCS_GEARBOX_TX_IDLE_EN to fill underflow cycles with idle control blocks (2'b10, 64'h1E).
module pcs_gearbox_tx #(
  parameter int HEAD_W  = 2,
  parameter int DATA_W  = 64,
  parameter int BLOCK_W = HEAD_W + DATA_W,
  parameter int SEQ_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [HEAD_W-1:0] head_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  // Number of blocks after which the residue holds a whole output word.
  localparam logic [SEQ_W-1:0] SEQ_MAX = SEQ_W'(DATA_W / HEAD_W);
  localparam int               SH_W    = SEQ_W + 2;
  localparam int               WIDE_W  = BLOCK_W + DATA_W;

`ifdef PCS_GEARBOX_TX_IDLE_EN
  // Idle control block: block type 0x1E with all-zero /I/ characters.
  localparam logic [BLOCK_W-1:0] IDLE_BLK = {DATA_W'(64'h1E), HEAD_W'(2'b10)};
`endif

  logic [SEQ_W-1:0]  seq, seq_nxt;
  logic [DATA_W-1:0] res, res_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              valid_nxt;

  logic [BLOCK_W-1:0] blk_sel;
  logic               take;
  logic [SH_W-1:0]    sh;
  logic [WIDE_W-1:0]  shifted;
  logic [DATA_W-1:0]  res_mask;

  // Ready only depends on reset and whether the residue is full.
  always_comb begin
    ready_o = !reset && (seq != SEQ_MAX);
  end

  // Next-state: flush full residue, pack an accepted block, or stall.
  always_comb begin
    seq_nxt   = seq;
    res_nxt   = res;
    data_nxt  = data_o;
    valid_nxt = 1'b0;

    blk_sel = {data_i, head_i};
    take    = valid_i && ready_o;
`ifdef PCS_GEARBOX_TX_IDLE_EN
    // Underflow cycles advance the gearbox with an idle block instead of stalling.
    if (!valid_i) begin
      blk_sel = IDLE_BLK;
    end
    take = ready_o;
`endif

    // Residue holds HEAD_W*seq valid bits; the new block lands just above them.
    sh       = SH_W'(seq) * SH_W'(HEAD_W);
    shifted  = {{DATA_W{1'b0}}, blk_sel} << sh;
    // Mask keeps any stale residue bits above the valid count out of data_o.
    res_mask = ~({DATA_W{1'b1}} << sh);

    if (seq == SEQ_MAX) begin
      data_nxt  = res;
      valid_nxt = 1'b1;
      res_nxt   = '0;
      seq_nxt   = '0;
    end else if (take) begin
      data_nxt  = shifted[DATA_W-1:0] | (res & res_mask);
      res_nxt   = shifted[2*DATA_W-1:DATA_W];
      valid_nxt = 1'b1;
      seq_nxt   = seq + 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq     <= '0;
      res     <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      seq     <= seq_nxt;
      res     <= res_nxt;
      data_o  <= data_nxt;
      valid_o <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_pcs_gearbox_tx.sv
module tb_pcs_gearbox_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic [1:0]  head_i;
  logic [63:0] data_i;
  logic        ready_o;
  logic        valid_o;
  logic [63:0] data_o;

  int checks = 0;
  int errors = 0;

  // Reference model: serial stream as a bit queue of not-yet-emitted bits.
  bit          pq[$];
  bit          outq[$];
  logic [63:0] exp_data;
  logic        exp_valid;

  always #5 clk = ~clk;

  pcs_gearbox_tx dut (
    .clk     (clk),
    .reset   (reset),
    .valid_i (valid_i),
    .head_i  (head_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o)
  );

  // One clock: drive inputs, predict, check ready before the edge, outputs after.
  task automatic cycle(input logic v, input logic [1:0] h, input logic [63:0] d,
                       output logic acc, output logic rdy_seen);
    logic [65:0] blk;
    logic        use_blk;
    logic        exp_ready;
    valid_i = v; head_i = h; data_i = d;
    #1;
    rdy_seen  = ready_o;
    exp_ready = (pq.size() < 64);
    acc       = 1'b0;
    exp_valid = 1'b0;
    if (!exp_ready) begin
      for (int i = 0; i < 64; i++) exp_data[i] = pq.pop_front();
      exp_valid = 1'b1;
    end else begin
      blk     = {d, h};
      use_blk = v;
`ifdef PCS_GEARBOX_TX_IDLE_EN
      if (!v) begin
        blk     = {64'h1E, 2'b10};
        use_blk = 1'b1;
      end
`endif
      if (use_blk) begin
        for (int i = 0; i < 66; i++) pq.push_back(blk[i]);
        for (int i = 0; i < 64; i++) exp_data[i] = pq.pop_front();
        exp_valid = 1'b1;
        acc       = v;
      end
    end
    checks++;
    if (ready_o !== exp_ready) begin
      errors++;
      $display("FAIL ready_o got %b exp %b at %0t", ready_o, exp_ready, $time);
    end
    @(posedge clk); #1;
    checks++;
    if (valid_o !== exp_valid) begin
      errors++;
      $display("FAIL valid_o got %b exp %b at %0t", valid_o, exp_valid, $time);
    end
    checks++;
    if (data_o !== exp_data) begin
      errors++;
      $display("FAIL data_o got %h exp %h at %0t", data_o, exp_data, $time);
    end
    if (valid_o === 1'b1) begin
      for (int i = 0; i < 64; i++) outq.push_back(data_o[i]);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; valid_i = 1'b0; head_i = '0; data_i = '0;
    for (int i = 0; i < n; i++) begin
      #1;
      checks++;
      if (ready_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_ready got %b exp 0", ready_o);
      end
      @(posedge clk); #1;
      checks++;
      if (valid_o !== 1'b0 || data_o !== 64'h0) begin
        errors++;
        $display("FAIL reset_out got valid %b data %h exp valid 0 data 0", valid_o, data_o);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready got %b exp 1", ready_o);
    end
    pq.delete();
    exp_data  = '0;
    exp_valid = 1'b0;
  endtask

  function automatic logic [1:0] rand_head();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [63:0] rand_data();
    return {$urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    do_reset(3);
  endtask

  task automatic test_directed();
    logic acc, rdy;
    do_reset(1);
    cycle(1'b1, 2'b01, 64'h0, acc, rdy);
    checks++;
    if (data_o !== 64'h0000_0000_0000_0001) begin
      errors++;
      $display("FAIL word0 got %h exp 0000000000000001", data_o);
    end
    cycle(1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, acc, rdy);
    checks++;
    if (data_o !== 64'hFFFF_FFFF_FFFF_FFF8) begin
      errors++;
      $display("FAIL word1 got %h exp fffffffffffffff8", data_o);
    end
  endtask

  task automatic test_back_to_back();
    logic acc, rdy;
    logic [1:0]  h;
    logic [63:0] d;
    int n_acc, n_words, n_bad_rdy;
    do_reset(1);
    n_acc = 0; n_words = 0; n_bad_rdy = 0;
    h = rand_head(); d = rand_data();
    for (int i = 0; i < 66; i++) begin
      cycle(1'b1, h, d, acc, rdy);
      if (rdy !== !(i == 32 || i == 65)) n_bad_rdy++;
      if (acc) begin
        n_acc++;
        h = rand_head(); d = rand_data();
      end
      if (valid_o === 1'b1) n_words++;
    end
    checks++;
    if (n_bad_rdy != 0) begin
      errors++;
      $display("FAIL b2b_ready_pattern got %0d wrong cycles exp 0", n_bad_rdy);
    end
    checks++;
    if (n_acc != 64) begin
      errors++;
      $display("FAIL b2b_accepted got %0d exp 64", n_acc);
    end
    checks++;
    if (n_words != 66) begin
      errors++;
      $display("FAIL b2b_words got %0d exp 66", n_words);
    end
  endtask

  task automatic test_underflow();
    logic acc, rdy;
    logic [63:0] held;
    do_reset(1);
    for (int i = 0; i < 5; i++) cycle(1'b1, rand_head(), rand_data(), acc, rdy);
    held = data_o;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, rand_head(), rand_data(), acc, rdy);
`ifdef PCS_GEARBOX_TX_IDLE_EN
      checks++;
      if (valid_o !== 1'b1) begin
        errors++;
        $display("FAIL idle_valid got %b exp 1", valid_o);
      end
`else
      checks++;
      if (valid_o !== 1'b0 || data_o !== held) begin
        errors++;
        $display("FAIL stall_hold got valid %b data %h exp valid 0 data %h", valid_o, data_o, held);
      end
`endif
    end
    for (int i = 0; i < 40; i++) begin
      cycle(($urandom_range(0, 3) != 0), rand_head(), rand_data(), acc, rdy);
    end
  endtask

  task automatic test_reset_mid();
    logic acc, rdy;
    logic [1:0]  h;
    logic [63:0] d;
    do_reset(1);
    for (int i = 0; i < 17; i++) cycle(1'b1, rand_head(), rand_data(), acc, rdy);
    do_reset(1);
    h = 2'b10; d = rand_data();
    cycle(1'b1, h, d, acc, rdy);
    checks++;
    if (data_o[1:0] !== h) begin
      errors++;
      $display("FAIL mid_reset_head got %b exp %b", data_o[1:0], h);
    end
  endtask

  task automatic test_lock();
    logic acc, rdy;
    logic [1:0]  h;
    logic [63:0] d;
    int nblk, lock_off, bad;
    do_reset(1);
    outq.delete();
    h = rand_head(); d = rand_data();
    for (int i = 0; i < 110; i++) begin
      cycle(1'b1, h, d, acc, rdy);
      if (acc) begin
        h = rand_head(); d = rand_data();
      end
    end
    // Block sync: first offset with 64 consecutive valid headers (01 or 10).
    lock_off = -1;
    for (int off = 0; off < 66 && lock_off < 0; off++) begin
      int run = 0;
      for (int b = 0; off + 66 * b + 1 < outq.size() && run < 64; b++) begin
        if (outq[off + 66 * b] != outq[off + 66 * b + 1]) run++;
        else run = 0;
        if (run == 64 && b < 64) lock_off = off;
      end
    end
    checks++;
    if (lock_off != 0) begin
      errors++;
      $display("FAIL lock_offset got %0d exp 0", lock_off);
    end
    nblk = outq.size() / 66;
    bad = 0;
    for (int b = 0; b < nblk; b++) begin
      if (outq[66 * b] == outq[66 * b + 1]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL lock_slip got %0d bad headers exp 0", bad);
    end
  endtask

  initial begin
    reset = 1'b1; valid_i = 1'b0; head_i = '0; data_i = '0;
    exp_data = '0; exp_valid = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_underflow();
    test_reset_mid();
    test_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcs_gearbox_tx.md
Name: pcs_gearbox_tx

Overview:
Transmit-side 66b→64b gearbox for the 10GBASE-R PCS. It sits between the TX scrambler/encoder and the 64-bit SerDes parallel interface. It takes one 66-bit block per cycle as a 2-bit sync header plus 64-bit payload, and packs the blocks back-to-back into a continuous 64-bit word stream with the sync header transmitted first. It is the transmit counterpart of the RX block-sync/lock logic: its output is what that logic must lock onto.

Parameters:
HEAD_W, 2, sync header width
DATA_W, 64, block payload width and output word width
BLOCK_W, HEAD_W+DATA_W (66), full block width
SEQ_W, 6, width of the gearbox sequence counter (holds 0..32)

Ports:
clk      input   1       clock
reset    input   1       synchronous reset, active-high
valid_i  input   1       head_i/data_i carry a block
head_i   input   HEAD_W  sync header; bit 0 is transmitted first
data_i   input   DATA_W  scrambled payload; bit 0 is transmitted first after the header
ready_o  output  1       gearbox accepts a block this cycle
valid_o  output  1       data_o holds a valid SerDes word
data_o   output  DATA_W  SerDes word; bit 0 is transmitted first

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset).
- Block and stream format: blk = {data_i, head_i}, so head_i sits at bits [1:0]. The serial stream S is the concatenation of blocks, LSB first. Output word n is S[64n+63:64n].
- State: seq counter (0..32) and residual register res[63:0], holding 2*seq valid bits in the LSBs.
- ready_o is combinational: ready_o = !reset && (seq != 32).
- Accept: accept = valid_i && ready_o. When ready_o=0, a presented block is not consumed, and upstream holds it.
- seq = k < 32 and accept:
  - data_o <= {blk[63-2k:0], res[2k-1:0]} (k=0: data_o <= blk[63:0])
  - res <= blk[65:64-2k] (2k+2 bits)
  - valid_o <= 1
  - seq <= k+1
- seq = 32 (res holds 64 bits): data_o <= res, valid_o <= 1, res <= 0, seq <= 0. No input is accepted. This happens regardless of valid_i.
- Throughput: exactly 32 blocks accepted per 33 cycles under continuous valid_i. ready_o is low on one cycle in 33.
- seq < 32 and valid_i = 0 (underflow):
  - seq, res held
  - valid_o <= 0, data_o holds its previous value
  - Resuming later loses no bits.
- Latency: 1 cycle from accept to the corresponding data_o/valid_o.
- Reset values: seq=0, res=0, data_o=0, valid_o=0, ready_o=0 while reset is high and 1 on the first cycle after reset.
- Reset mid-operation: any residual bits are discarded, and the next accepted block starts at word offset 0.
- Unused res bits above 2*seq are don't-care internally but must not leak into data_o.

Optional Feature:
Macro: PCS_GEARBOX_TX_IDLE_EN
- Defined: on underflow (seq<32, valid_i=0), the gearbox internally substitutes an idle control block, head=2'b10 and data=64'h1E (block type 0x1E, all /I/). It advances exactly as for an accepted block. valid_o is therefore 1 on every cycle after reset. ready_o is unchanged.
- Not defined: underflow stalls as described above.

Test Plan:
- Reset held 3 cycles, then released → valid_o=0 and data_o=0 during reset; ready_o=1 on the first cycle after release; seq=0.
- Block0 head=2'b01, data=0, then block1 head=2'b10, data=64'hFFFF_FFFF_FFFF_FFFF, back-to-back → word0 = 64'h0000_0000_0000_0001; word1 = 64'hFFFF_FFFF_FFFF_FFF8 (res 2'b00, then header 10, then ones) after 1 cycle of latency.
- 66 consecutive valid blocks of random content → ready_o low exactly on cycles 32 and 65. 64 blocks accepted, 66 words out. A reference model reconstructing S from data_o matches all blocks bit-exact.
- valid_i low for 3 cycles while seq=5 → valid_o=0 for those 3 cycles, data_o stable. After resume, the reconstructed stream has no gap or duplicated bits (macro undefined). With PCS_GEARBOX_TX_IDLE_EN defined, 3 idle blocks (2'b10, 64'h1E) appear in the stream instead.
- reset asserted for 1 cycle while seq=17 → next cycle seq=0, ready_o=1; the first post-reset block appears at data_o[1:0]=head_i.
- Continuous random valid blocks through the gearbox, an inverse 64→66 model and the RX block-sync logic → lock within 64 blocks, with no slip pulse after lock.
